// File: rtl/mdu_div_if.sv
// Handshake/result bundle for the iterative divider (mdu_div).
// state_o mirrors the divider FSM state for observation only.
interface mdu_div_if;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stall_div_o;
    logic        ready_o;
    logic [31:0] quot_o;
    logic [31:0] rem_o;
    logic [1:0]  state_o;

    // Handshake: start_i is held while stall_div_o=1; ready_o is a one-cycle
    // pulse, and quot_o/rem_o are valid from that cycle until the next ready_o.
    modport master (
        output start_i, signed_i, annul_i, a_i, b_i,
        input  stall_div_o, ready_o, quot_o, rem_o, state_o
    );
    modport slave (
        input  start_i, signed_i, annul_i, a_i, b_i,
        output stall_div_o, ready_o, quot_o, rem_o, state_o
    );
endinterface

// File: rtl/mdu_div.sv
// 32-bit restoring radix-2 DIV/DIVU unit: 33 stall cycles, results at the
// following cycle. Optional macro DIV_ZERO_FAST_EN short-circuits divide-by-zero.
module mdu_div (
    input  logic       clk,
    input  logic       resetn,
    mdu_div_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvs_q, dvs_d;
    logic        sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d;
    logic [31:0] quot_q, quot_d, rem_q, rem_d;

    logic        a_neg, b_neg, zero_fast, sub_ok;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, diff;
    logic [63:0] acc_step;

    always_comb begin
        a_neg  = bus.signed_i & bus.a_i[31];
        b_neg  = bus.signed_i & bus.b_i[31];
        a_mag  = a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
        b_mag  = b_neg ? (~bus.b_i + 32'd1) : bus.b_i;
        // A set bit 32 in the shifted remainder already exceeds any divisor.
        rem_sh = acc_q[63:31];
        diff   = rem_sh - {1'b0, dvs_q};
        sub_ok = rem_sh[32] | ~diff[32];
        acc_step = sub_ok ? {diff[31:0], acc_q[30:0], 1'b1}
                          : {rem_sh[31:0], acc_q[30:0], 1'b0};
`ifdef DIV_ZERO_FAST_EN
        zero_fast = (bus.b_i == 32'd0);
`else
        zero_fast = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    sgn_d = bus.signed_i;
                    cnt_d = 6'd0;
                    if (zero_fast) begin
                        quot_d  = 32'hFFFF_FFFF;
                        rem_d   = bus.a_i;
                        state_d = DONE;
                    end else begin
                        acc_d   = {32'd0, a_mag};
                        dvs_d   = b_mag;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.annul_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DONE;
                        quot_d  = (sgn_q && (sa_q ^ sb_q)) ? (~acc_step[31:0] + 32'd1)
                                                           : acc_step[31:0];
                        rem_d   = (sgn_q && sa_q) ? (~acc_step[63:32] + 32'd1)
                                                  : acc_step[63:32];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            dvs_q   <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sgn_q   <= sgn_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Stall is gated by reset so the hazard unit sees no stall while held in reset.
    assign bus.stall_div_o = resetn && !bus.annul_i &&
                             (((state_q == IDLE) && bus.start_i) || (state_q == RUN));
    assign bus.ready_o     = (state_q == DONE);
    assign bus.quot_o      = quot_q;
    assign bus.rem_o       = rem_q;
    assign bus.state_o     = state_q;
endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 The block SHALL have these ports (clock and reset first); one clock, reset asynchronous and active-low:
  clk  in  1  sole clock, rising edge
  resetn  in  1  asynchronous active-low reset
  start_i  in  1  DIV/DIVU present in execute stage; held high while execute is stalled
  signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
  annul_i  in  1  execute-stage flush/exception; cancels any operation
  a_i  in  32  dividend (rs), sampled at start
  b_i  in  32  divisor (rt), sampled at start
  stall_div_o  out  1  to hazard unit as stall_divE; holds fetch/decode/execute
  ready_o  out  1  one-cycle pulse, results valid
  quot_o  out  32  quotient (LO)
  rem_o  out  32  remainder (HI)

Function
REQ-002 The FSM SHALL have states IDLE, RUN, DONE.
REQ-003 IDLE: when start_i=1 and annul_i=0 at edge T, the block SHALL latch |a_i|, |b_i| (magnitudes only if signed_i=1), sign(a), sign(b) and signed_i, clear the 6-bit iteration counter, and enter RUN.
REQ-004 RUN SHALL perform one restoring radix-2 step per cycle on a 64-bit partial-remainder/quotient register using a 33-bit subtract, for exactly 32 cycles, then enter DONE.
REQ-005 On entering DONE, quot_o and rem_o SHALL be registered: quotient negated if signed and sign(a)^sign(b); remainder negated if signed and sign(a); all arithmetic modulo 2^32.
REQ-006 DONE SHALL last exactly one cycle with ready_o=1, then return to IDLE unconditionally; no restart on the same instruction.
REQ-007 stall_div_o SHALL be combinational: 1 when (IDLE and start_i and not annul_i) or RUN, and annul_i=0; 0 in DONE.
REQ-008 Latency: start seen at cycle T -> stall_div_o high cycles T..T+32 (33 cycles), ready_o and valid results at T+33.
REQ-009 annul_i=1 in RUN SHALL force IDLE at the next edge, with no ready_o pulse and quot_o/rem_o unchanged.
REQ-010 quot_o/rem_o SHALL hold their last value until the next DONE.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL give quot 0x80000000, rem 0 (no trap).
REQ-012 start_i asserted in RUN or DONE SHALL be ignored.

Reset
REQ-013 resetn=0 SHALL asynchronously force IDLE, counter 0, datapath registers 0, quot_o=0, rem_o=0, ready_o=0; stall_div_o=0 while resetn=0.
REQ-014 Reset mid-RUN SHALL abandon the operation with no ready_o pulse; the first edge after release behaves as IDLE.

Configuration
REQ-015 Macro DIV_ZERO_FAST_EN: when defined, b_i=0 at start SHALL go IDLE->DONE directly (stall high for 1 cycle, ready_o at T+1) with quot_o=0xFFFFFFFF and rem_o=a_i unmodified, in both signed and unsigned modes.
REQ-016 Without DIV_ZERO_FAST_EN, divide-by-zero SHALL take the full 33-cycle path; results are the algorithm's output (architecturally unpredictable), and only timing is checked.

Verification
REQ-017 DIVU a=100, b=7, start at T -> stall T..T+32, ready_o at T+33, quot=14, rem=2.
REQ-018 DIV a=-7 (0xFFFFFFF9), b=2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-019 DIVU a=5, b=0: with DIV_ZERO_FAST_EN -> ready_o at T+1, quot=0xFFFFFFFF, rem=5; without -> ready_o at T+33.
REQ-020 Start DIVU 50/5, assert annul_i at T+10 -> stall_div_o low same cycle, IDLE at T+11, no ready_o, quot/rem keep previous values.
REQ-021 resetn low at T+20 of a divide -> outputs 0 immediately; back-to-back DIVU 9/3 then 10/4 after release -> (3,0) then (2,2), each 33-cycle stall, a single ready_o pulse each.
